// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, redirect-source codes and
// the select bundle produced by the next-PC mux.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JAL  = 3'd2,
        SRC_JALR = 3'd3,
        SRC_TRAP = 3'd4
    } src_e;

    typedef struct packed {
        logic [31:0] tgt;
        src_e        src;
    } sel_t;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between hazard+branch logic, the PC sequencer and imem.
interface pc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic        trap;
    logic [31:0] pc_imm;
    logic [31:0] pc_add4;
    logic [31:0] jalr_target;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_exc;

    modport master (
        input  stall, branch_taken, jal, jalr, trap,
        input  pc_imm, pc_add4, jalr_target, fetch_ready,
        output pc, fetch_valid, flush, misalign_exc
    );

    modport slave (
        output stall, branch_taken, jal, jalr, trap,
        output pc_imm, pc_add4, jalr_target, fetch_ready,
        input  pc, fetch_valid, flush, misalign_exc
    );
endinterface

// File: rtl/pc_next_mux.sv
// Priority select of the next PC: trap > jalr > jal > branch > sequential.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic        branch_taken_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic        trap_i,
    input  logic [31:0] pc_imm_i,
    input  logic [31:0] pc_add4_i,
    input  logic [31:0] jalr_target_i,
    output sel_t        sel_o
);

    always_comb begin
        sel_o.tgt = pc_add4_i;
        sel_o.src = SRC_SEQ;
        if (trap_i) begin
            sel_o.tgt = TRAP_VECTOR;
            sel_o.src = SRC_TRAP;
        end else if (jalr_i) begin
            sel_o.tgt = {jalr_target_i[31:1], 1'b0};
            sel_o.src = SRC_JALR;
        end else if (jal_i) begin
            sel_o.tgt = pc_imm_i;
            sel_o.src = SRC_JAL;
        end else if (branch_taken_i) begin
            sel_o.tgt = pc_imm_i;
            sel_o.src = SRC_BR;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register and fetch sequencer with a one-entry redirect queue.
// Build option: PC_MISALIGN_CHECK_EN redirects misaligned targets to TRAP_VECTOR.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_trap_q, redir_trap_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;
    sel_t        sel;
    logic        adv, redir, is_trap, pend_upd, load_redir;
    logic [31:0] load_tgt;

    pc_next_mux #(.TRAP_VECTOR(TRAP_VECTOR)) u_mux (
        .branch_taken_i (bus.branch_taken),
        .jal_i          (bus.jal),
        .jalr_i         (bus.jalr),
        .trap_i         (bus.trap),
        .pc_imm_i       (bus.pc_imm),
        .pc_add4_i      (bus.pc_add4),
        .jalr_target_i  (bus.jalr_target),
        .sel_o          (sel)
    );

    assign redir   = (sel.src != SRC_SEQ);
    assign is_trap = (sel.src == SRC_TRAP);
    assign adv     = bus.fetch_valid & bus.fetch_ready & ~bus.stall;
    // A queued trap is sticky: only another trap may replace it.
    assign pend_upd = redir & ~(redir_trap_q & ~is_trap);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        redir_trap_d = redir_trap_q;
        flush_d      = 1'b0;
        mis_d        = 1'b0;
        load_redir   = 1'b0;
        load_tgt     = sel.tgt;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (adv) begin
                    if (redir) load_redir = 1'b1;
                    else       pc_d       = sel.tgt;
                end else if (redir) begin
                    redir_pc_d   = sel.tgt;
                    redir_trap_d = is_trap;
                    state_d      = ST_PEND;
                end
            end
            ST_PEND: begin
                if (pend_upd) begin
                    redir_pc_d   = sel.tgt;
                    redir_trap_d = is_trap;
                end
                if (adv) begin
                    load_redir   = 1'b1;
                    load_tgt     = pend_upd ? sel.tgt : redir_pc_q;
                    redir_trap_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (load_redir) begin
            flush_d = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
            if (misaligned(load_tgt)) begin
                pc_d  = TRAP_VECTOR;
                mis_d = 1'b1;
            end else begin
                pc_d = load_tgt;
            end
`else
            pc_d = load_tgt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            redir_pc_q   <= RESET_VECTOR;
            redir_trap_q <= 1'b0;
            flush_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_trap_q <= redir_trap_d;
            flush_q      <= flush_d;
            mis_q        <= mis_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state_q != ST_BOOT);
    assign bus.flush       = flush_q;
`ifdef PC_MISALIGN_CHECK_EN
    assign bus.misalign_exc = mis_q;
`else
    assign bus.misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow the build's PC_MISALIGN_CHECK_EN setting.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External pc_adder model
    assign bus.pc_add4 = bus.pc + 32'd4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        bus.branch_taken = 1'b0;
        bus.jal          = 1'b0;
        bus.jalr         = 1'b0;
        bus.trap         = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [31:0] pc, input logic fv, input logic fl);
        chk({tag, ".pc"},    bus.pc,                 pc);
        chk({tag, ".valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
        chk({tag, ".flush"}, {31'd0, bus.flush},       {31'd0, fl});
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.fetch_ready = 1'b1;
        bus.pc_imm      = 32'd0;
        bus.jalr_target = 32'd0;
        clr_ev();

        // 1: reset, BOOT, sequential fetch
        step(); step();
        chk3("rst", 32'h0, 1'b0, 1'b0);
        chk("rst.mis", {31'd0, bus.misalign_exc}, 32'd0);
        rst = 1'b0;
        chk("boot.valid", {31'd0, bus.fetch_valid}, 32'd0);
        step(); chk3("run0", 32'h0, 1'b1, 1'b0);
        step(); chk3("seq4", 32'h4, 1'b1, 1'b0);
        step(); chk3("seq8", 32'h8, 1'b1, 1'b0);
        step(); step(); chk3("seq10", 32'h10, 1'b1, 1'b0);

        // 2: taken branch
        bus.branch_taken = 1'b1; bus.pc_imm = 32'h40;
        step(); chk3("br", 32'h40, 1'b1, 1'b1);
        clr_ev();
        step(); chk3("br.after", 32'h44, 1'b1, 1'b0);

        // 3: jal under back-pressure
        bus.jal = 1'b1; bus.pc_imm = 32'h20;
        step(); chk3("jal20", 32'h20, 1'b1, 1'b1);
        bus.pc_imm = 32'h80; bus.fetch_ready = 1'b0;
        step(); chk3("bp1", 32'h20, 1'b1, 1'b0);
        clr_ev();
        step(); chk3("bp2", 32'h20, 1'b1, 1'b0);
        step(); chk3("bp3", 32'h20, 1'b1, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk3("jal80", 32'h80, 1'b1, 1'b1);

        // 4: trap beats jalr; queued trap beats later jal
        bus.trap = 1'b1; bus.jalr = 1'b1; bus.jalr_target = 32'h200;
        step(); chk3("trap", 32'h100, 1'b1, 1'b1);
        clr_ev();
        step(); chk3("trap.seq", 32'h104, 1'b1, 1'b0);
        bus.fetch_ready = 1'b0; bus.trap = 1'b1;
        step(); chk3("pend.trap", 32'h104, 1'b1, 1'b0);
        clr_ev(); bus.jal = 1'b1; bus.pc_imm = 32'h80;
        step(); chk3("pend.jal", 32'h104, 1'b1, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk3("pend.load", 32'h100, 1'b1, 1'b1);
        clr_ev();

        // stall with redirect queues it
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.pc_imm = 32'h60;
        step(); chk3("stall.br", 32'h100, 1'b1, 1'b0);
        clr_ev();
        step(); chk3("stall.hold", 32'h100, 1'b1, 1'b0);
        bus.stall = 1'b0;
        step(); chk3("stall.load", 32'h60, 1'b1, 1'b1);

        // 5: misaligned jalr, aligned jal
        bus.jalr = 1'b1; bus.jalr_target = 32'h303;
        step();
`ifdef PC_MISALIGN_CHECK_EN
        chk3("jalr303", 32'h100, 1'b1, 1'b1);
        chk("jalr303.mis", {31'd0, bus.misalign_exc}, 32'd1);
`else
        chk3("jalr303", 32'h302, 1'b1, 1'b1);
        chk("jalr303.mis", {31'd0, bus.misalign_exc}, 32'd0);
`endif
        clr_ev(); bus.jal = 1'b1; bus.pc_imm = 32'h44;
        step(); chk3("jal44", 32'h44, 1'b1, 1'b1);
        chk("jal44.mis", {31'd0, bus.misalign_exc}, 32'd0);

        // wrap-around
        bus.pc_imm = 32'hFFFF_FFFC;
        step(); chk3("jaltop", 32'hFFFF_FFFC, 1'b1, 1'b1);
        clr_ev();
        step(); chk3("wrap", 32'h0, 1'b1, 1'b0);

        // 6: reset in PEND discards the queued target
        bus.fetch_ready = 1'b0; bus.jal = 1'b1; bus.pc_imm = 32'h80;
        step(); chk3("pend80", 32'h0, 1'b1, 1'b0);
        clr_ev(); rst = 1'b1; bus.fetch_ready = 1'b1;
        step(); chk3("rst.pend", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk3("rst.run", 32'h0, 1'b1, 1'b0);
        step(); chk3("rst.seq", 32'h4, 1'b1, 1'b0);
        step(); chk3("rst.seq2", 32'h8, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
